pcie_axi_rd_splitter: RTL and testbench
=======================================

PCIE_AXI_RD_SPLITTER -- requirements
Module: pcie_axi_rd_splitter

Interface
REQ-001 The module SHALL take parameter AXI_ID_WIDTH, default 6: AR/R ID width.
REQ-002 The module SHALL take parameter AXI_ADDR_WIDTH, default 64: address width.
REQ-003 The module SHALL take parameter MAX_READ_REQ_SIZE, default 512: maximum bytes per sub-request; power of two, ≥32, ≤4096.
REQ-004 The module SHALL take parameter DATA_WIDTH, default 256: R data width; one beat is 32 bytes.
REQ-005 The module SHALL take parameter PEND_DEPTH_LG2, default 3: log2 of pending-sub-request FIFO depth.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 s_axi_arvalid/s_axi_arready  in/out  1/1  upstream AR handshake.
REQ-009 s_axi_arid/araddr/arlen  in  ID/ADDR/8  upstream request; arsize fixed 3'd5, arburst fixed INCR.
REQ-010 s_axi_arcache/arprot/arqos/arregion  in  4/3/4/4  captured and forwarded unchanged on every sub-request.
REQ-011 m_axi_ar* (same set as REQ-008..010)  out (arready in)  downstream AR to PCIE_TOP slave port; m_axi_arsize=3'd5, m_axi_arburst=2'b01.
REQ-012 m_axi_rvalid/rid/rdata/rresp/rlast  in  1/ID/DATA/2/1  downstream R beats.
REQ-013 m_axi_rready  out  1  equals s_axi_rready.
REQ-014 s_axi_rvalid/rid/rdata/rresp/rlast  out  1/ID/DATA/2/1  upstream R beats.
REQ-015 s_axi_rready  in  1  upstream R backpressure.
REQ-016 err_o  out  1  sticky protocol-error flag.

Function
REQ-017 FSM states SHALL be IDLE and SPLIT; reset state IDLE.
REQ-018 In IDLE, s_axi_arready SHALL be 1; in SPLIT, 0.
REQ-019 On s_axi_arvalid&s_axi_arready the module SHALL capture id/addr/attributes, set rem_beats=arlen+1 (9-bit), and enter SPLIT.
REQ-020 In SPLIT, m_axi_arvalid SHALL be 1 unless the pending FIFO is full; first assertion is the cycle after capture.
REQ-021 Sub-request beat count SHALL be min(rem_beats, (MAX_READ_REQ_SIZE - (cur_addr mod MAX_READ_REQ_SIZE))/32); m_axi_arlen = count-1; m_axi_araddr = cur_addr.
REQ-022 Addresses SHALL be treated as 32-byte aligned; araddr[4:0] SHALL be forwarded on the first sub-request only and zeroed on later ones.
REQ-023 Because 4 KB is a multiple of MAX_READ_REQ_SIZE, no sub-request SHALL cross a 4 KB boundary.
REQ-024 On each m_axi_arvalid&m_axi_arready the module SHALL:
  - add count*32 to cur_addr;
  - subtract count from rem_beats;
  - push last_sub=(rem_beats==count) into the FIFO.
REQ-025 Sub-requests SHALL issue back-to-back, one per cycle, while m_axi_arready=1 and the FIFO is not full.
REQ-026 After the handshake of the last sub-request the FSM SHALL return to IDLE next cycle.
REQ-027 All m_axi_ar* outputs SHALL hold stable while m_axi_arvalid=1 and m_axi_arready=0.
REQ-028 The R path SHALL be combinational pass-through with zero latency:
  - s_axi_rvalid=m_axi_rvalid;
  - rid, rdata, rresp passed unchanged.
REQ-029 s_axi_rlast SHALL equal m_axi_rlast & fifo_head.last_sub.
REQ-030 The FIFO SHALL pop on m_axi_rvalid&m_axi_rready&m_axi_rlast.
REQ-031 A simultaneous push and pop SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-032 An R beat with m_axi_rlast=1 while the FIFO is empty SHALL set err_o.
  - That beat's s_axi_rlast SHALL equal m_axi_rlast.
  - No pop SHALL occur.
REQ-033 err_o SHALL clear only on reset.
REQ-034 Requests SHALL be processed strictly in order; a single outstanding original request is split at a time.

Reset
REQ-035 While rst_n=0 the following SHALL all be 0: FSM=IDLE, m_axi_arvalid, FIFO empty, err_o, rem_beats, cur_addr.
REQ-036 s_axi_arready SHALL be 1 after reset, since the FSM is in IDLE.
REQ-037 Reset asserted mid-SPLIT SHALL discard the captured request and all pending entries, with no further sub-requests issued.

Verification
REQ-038 araddr=0x1000, arlen=15 -> one sub-request addr 0x1000 len 15; s_axi_rlast on beat 16.
REQ-039 araddr=0x1000, arlen=31 -> subs (0x1000, len 15) then (0x1200, len 15) on consecutive cycles; s_axi_rlast only on beat 32.
REQ-040 araddr=0x11C0, arlen=3 -> subs (0x11C0, len 1), (0x1200, len 1); s_axi_rlast only on beat 4.
REQ-041 PEND_DEPTH_LG2=3, m_axi_rvalid held 0, araddr=0x0, arlen=255 -> 8 subs issued, then m_axi_arvalid=0; after one full sub-burst returns, the 9th sub (addr 0x1000) issues.
REQ-042 rst_n pulsed low during SPLIT after 2 of 4 subs -> m_axi_arvalid=0 and s_axi_arready=1 the cycle after release; FIFO empty.
REQ-043 m_axi_rvalid=1, m_axi_rlast=1 with empty FIFO -> err_o=1 next cycle and remains 1 until reset.

Source files
------------

// File: rtl/pcie_axi_rd_splitter.sv
// Splits upstream AXI INCR reads into MAX_READ_REQ_SIZE-aligned sub-requests toward the PCIe
// slave port and merges the returned R stream so only the final sub-burst carries rlast.
module pcie_axi_rd_splitter #(
    parameter int unsigned AXI_ID_WIDTH      = 6,
    parameter int unsigned AXI_ADDR_WIDTH    = 64,
    parameter int unsigned MAX_READ_REQ_SIZE = 512,
    parameter int unsigned DATA_WIDTH        = 256,
    parameter int unsigned PEND_DEPTH_LG2    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [3:0]                s_axi_arcache,
    input  logic [2:0]                s_axi_arprot,
    input  logic [3:0]                s_axi_arqos,
    input  logic [3:0]                s_axi_arregion,

    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic [3:0]                m_axi_arregion,

    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,

    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,

    output logic                      err_o
);

    localparam int unsigned BEAT_LG2    = 5;
    localparam int unsigned MRRS_BEATS  = MAX_READ_REQ_SIZE / 32;
    localparam int unsigned PEND_DEPTH  = 1 << PEND_DEPTH_LG2;
    localparam int unsigned CNT_W       = PEND_DEPTH_LG2 + 1;
    localparam int unsigned BEAT_ADDR_W = AXI_ADDR_WIDTH - BEAT_LG2;

    typedef enum logic {IDLE, SPLIT} state_t;

    // Beats until the next MRRS boundary, capped by what remains of the request.
    function automatic logic [8:0] sub_beats(input logic [6:0] blk, input logic [8:0] rem);
        logic [8:0] off;
        logic [8:0] room;
        off  = 9'(blk) & 9'(MRRS_BEATS - 1);
        room = 9'(MRRS_BEATS) - off;
        return (rem < room) ? rem : room;
    endfunction

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [8:0]                rem_q, rem_d;
    logic                      arvalid_q, arvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]                arlen_q, arlen_d;
    logic [AXI_ID_WIDTH-1:0]   arid_q, arid_d;
    logic [3:0]                cache_q, cache_d;
    logic [2:0]                prot_q, prot_d;
    logic [3:0]                qos_q, qos_d;
    logic [3:0]                region_q, region_d;
    logic                      err_q, err_d;

    logic [PEND_DEPTH-1:0]     fifo_q;
    logic [PEND_DEPTH_LG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic       ar_hs;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic [8:0] sub_cnt;
    logic       last_sub;

    always_comb begin
        ar_hs      = arvalid_q & m_axi_arready;
        push       = ar_hs;
        fifo_empty = (cnt_q == '0);
        pop        = m_axi_rvalid & s_axi_rready & m_axi_rlast & ~fifo_empty;
        cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
        sub_cnt    = 9'(arlen_q) + 9'd1;
        last_sub   = (rem_q == sub_cnt);
    end

    // Next-state for the splitter FSM and its registered AR outputs.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arid_d     = arid_q;
        cache_d    = cache_q;
        prot_d     = prot_q;
        qos_d      = qos_q;
        region_d   = region_q;
        err_d      = err_q | (m_axi_rvalid & m_axi_rlast & fifo_empty);

        case (state_q)
            IDLE: begin
                if (s_axi_arvalid) begin
                    state_d    = SPLIT;
                    cur_addr_d = s_axi_araddr;
                    rem_d      = 9'(s_axi_arlen) + 9'd1;
                    arid_d     = s_axi_arid;
                    cache_d    = s_axi_arcache;
                    prot_d     = s_axi_arprot;
                    qos_d      = s_axi_arqos;
                    region_d   = s_axi_arregion;
                end
            end
            SPLIT: begin
                if (ar_hs) begin
                    // Later sub-requests start on a beat boundary, so the byte offset is dropped.
                    cur_addr_d = {cur_addr_q[AXI_ADDR_WIDTH-1:BEAT_LG2] + BEAT_ADDR_W'(sub_cnt),
                                  5'b0};
                    rem_d      = rem_q - sub_cnt;
                    if (last_sub) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A presented but not yet accepted sub-request stays frozen.
        if (!(arvalid_q && !m_axi_arready)) begin
            arvalid_d = (state_d == SPLIT) && (cnt_d != CNT_W'(PEND_DEPTH));
            araddr_d  = cur_addr_d;
            arlen_d   = 8'(sub_beats(cur_addr_d[11:5], rem_d) - 9'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arid_q     <= '0;
            cache_q    <= '0;
            prot_q     <= '0;
            qos_q      <= '0;
            region_q   <= '0;
            err_q      <= 1'b0;
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arid_q     <= arid_d;
            cache_q    <= cache_d;
            prot_q     <= prot_d;
            qos_q      <= qos_d;
            region_q   <= region_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= last_sub;
                wr_ptr_q         <= wr_ptr_q + PEND_DEPTH_LG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PEND_DEPTH_LG2'(1);
            end
        end
    end

    assign s_axi_arready  = (state_q == IDLE);
    assign m_axi_arvalid  = arvalid_q;
    assign m_axi_araddr   = araddr_q;
    assign m_axi_arlen    = arlen_q;
    assign m_axi_arid     = arid_q;
    assign m_axi_arsize   = 3'd5;
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arcache  = cache_q;
    assign m_axi_arprot   = prot_q;
    assign m_axi_arqos    = qos_q;
    assign m_axi_arregion = region_q;
    assign err_o          = err_q;

    // R path is a zero-latency pass-through; only rlast is qualified by the pending FIFO.
    assign m_axi_rready = s_axi_rready;
    assign s_axi_rvalid = m_axi_rvalid;
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast & (fifo_empty | fifo_q[rd_ptr_q]);

endmodule

// File: tb/tb_pcie_axi_rd_splitter.sv
// Scoreboard bench for pcie_axi_rd_splitter: expected sub-requests and R beats are queued at
// stimulus time and checked by a negedge monitor against a simple downstream responder.
module tb_pcie_axi_rd_splitter;

    localparam int unsigned IDW = 6;
    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 256;
    localparam int unsigned CW  = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           s_axi_arvalid, s_axi_arready;
    logic [IDW-1:0] s_axi_arid;
    logic [AW-1:0]  s_axi_araddr;
    logic [7:0]     s_axi_arlen;
    logic [3:0]     s_axi_arcache, s_axi_arqos, s_axi_arregion;
    logic [2:0]     s_axi_arprot;
    logic           m_axi_arvalid, m_axi_arready;
    logic [IDW-1:0] m_axi_arid;
    logic [AW-1:0]  m_axi_araddr;
    logic [7:0]     m_axi_arlen;
    logic [2:0]     m_axi_arsize, m_axi_arprot;
    logic [1:0]     m_axi_arburst;
    logic [3:0]     m_axi_arcache, m_axi_arqos, m_axi_arregion;
    logic           m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [IDW-1:0] m_axi_rid;
    logic [DW-1:0]  m_axi_rdata;
    logic [1:0]     m_axi_rresp;
    logic           s_axi_rvalid, s_axi_rready, s_axi_rlast;
    logic [IDW-1:0] s_axi_rid;
    logic [DW-1:0]  s_axi_rdata;
    logic [1:0]     s_axi_rresp;
    logic           err_o;

    pcie_axi_rd_splitter dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arcache(s_axi_arcache),
        .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos), .s_axi_arregion(s_axi_arregion),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_arid(m_axi_arid),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rid(m_axi_rid),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .err_o(err_o)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [5:0]  id;
        logic [14:0] attr;
    } ar_t;

    typedef struct packed {
        logic [5:0] id;
        logic       last;
    } rb_t;

    typedef struct packed {
        logic [5:0] id;
        logic [7:0] len;
    } burst_t;

    ar_t         exp_ar[$];
    rb_t         exp_r[$];
    burst_t      rsp_q[$];
    int          ar_cyc[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ar_hs   = 0;
    int          beat    = 0;
    logic [63:0] rd_seq  = '0;
    logic [63:0] mon_seq = '0;
    logic [63:0] ar_snap = '0;

    logic r_auto      = 1'b1;
    logic rr_pat      = 1'b0;
    logic ar_pat      = 1'b0;
    logic ar_rdy_base = 1'b1;
    logic man_rvalid  = 1'b0;
    logic man_rlast   = 1'b0;
    logic man_rready  = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Downstream slave: accepts ARs per pattern and returns beats in AR order.
    initial begin
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rid     = '0;
        m_axi_rdata   = '0;
        m_axi_rresp   = '0;
        m_axi_rlast   = 1'b0;
        s_axi_rready  = 1'b1;
        forever begin
            @(posedge clk);
            if (r_auto && m_axi_rvalid && m_axi_rready) begin
                rd_seq++;
                if (m_axi_rlast) begin
                    beat = 0;
                    if (rsp_q.size() > 0) void'(rsp_q.pop_front());
                end else begin
                    beat++;
                end
            end
            #1;
            m_axi_arready = ar_pat ? (cyc % 3 == 0) : ar_rdy_base;
            if (r_auto) begin
                s_axi_rready = rr_pat ? (cyc % 4 != 1) : 1'b1;
                if (rsp_q.size() > 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rid    = rsp_q[0].id;
                    m_axi_rlast  = (beat == int'(rsp_q[0].len));
                    m_axi_rdata  = DW'(rd_seq);
                    m_axi_rresp  = 2'(rd_seq);
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                end
            end else begin
                m_axi_rvalid = man_rvalid;
                m_axi_rlast  = man_rlast;
                s_axi_rready = man_rready;
            end
        end
    end

    // Monitor: AR handshakes, AR stability under backpressure, upstream R beats.
    initial begin
        logic        prev_stall;
        logic [63:0] st_addr;
        logic [7:0]  st_len;
        ar_t         e;
        rb_t         r;
        prev_stall = 1'b0;
        st_addr    = '0;
        st_len     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("ar_hold_valid", CW'(m_axi_arvalid), CW'(1));
                    check("ar_hold_addr", CW'(m_axi_araddr), CW'(st_addr));
                    check("ar_hold_len", CW'(m_axi_arlen), CW'(st_len));
                end
                prev_stall = m_axi_arvalid && !m_axi_arready;
                st_addr    = m_axi_araddr;
                st_len     = m_axi_arlen;
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_hs++;
                    ar_snap = mon_seq;
                    ar_cyc.push_back(cyc);
                    rsp_q.push_back({m_axi_arid, m_axi_arlen});
                    if (exp_ar.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL ar_unexpected: got addr 0x%0h len %0d, expected none",
                                 m_axi_araddr, m_axi_arlen);
                    end else begin
                        e = exp_ar.pop_front();
                        check("ar_addr", CW'(m_axi_araddr), CW'(e.addr));
                        check("ar_len", CW'(m_axi_arlen), CW'(e.len));
                        check("ar_id", CW'(m_axi_arid), CW'(e.id));
                        check("ar_attr", CW'({m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion}),
                              CW'(e.attr));
                        check("ar_size_burst", CW'({m_axi_arsize, m_axi_arburst}), CW'({3'd5, 2'b01}));
                    end
                end
                if (r_auto && s_axi_rvalid && s_axi_rready) begin
                    if (exp_r.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL r_unexpected: got rid %0d rlast %0d, expected none",
                                 s_axi_rid, s_axi_rlast);
                    end else begin
                        r = exp_r.pop_front();
                        check("r_last", CW'(s_axi_rlast), CW'(r.last));
                        check("r_id", CW'(s_axi_rid), CW'(r.id));
                        check("r_data", CW'(s_axi_rdata), CW'(mon_seq));
                        check("r_resp", CW'(s_axi_rresp), CW'(mon_seq[1:0]));
                    end
                    mon_seq++;
                end
            end
        end
    end

    task automatic exp_sub(input logic [63:0] addr, input logic [7:0] len, input logic [5:0] id,
                           input logic [14:0] attr);
        exp_ar.push_back({addr, len, id, attr});
    endtask

    task automatic exp_burst(input logic [5:0] id, input int n);
        for (int i = 0; i < n; i++) exp_r.push_back({id, (i == n - 1)});
    endtask

    task automatic send_req(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [14:0] attr);
        logic got;
        got = 1'b0;
        @(negedge clk);
        s_axi_arvalid  = 1'b1;
        s_axi_arid     = id;
        s_axi_araddr   = addr;
        s_axi_arlen    = len;
        s_axi_arcache  = attr[14:11];
        s_axi_arprot   = attr[10:8];
        s_axi_arqos    = attr[7:4];
        s_axi_arregion = attr[3:0];
        for (int i = 0; i < 500; i++) begin
            #1;
            if (s_axi_arready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        if (!got) check("s_arready_timeout", CW'(0), CW'(1));
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #2;
            if (exp_ar.size() == 0 && exp_r.size() == 0 && rsp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", CW'(exp_ar.size() + exp_r.size()), CW'(0));
    endtask

    initial begin
        int          base;
        logic [63:0] seq0;
        logic        ok;
        rst_n          = 1'b0;
        s_axi_arvalid  = 1'b0;
        s_axi_arid     = '0;
        s_axi_araddr   = '0;
        s_axi_arlen    = '0;
        s_axi_arcache  = '0;
        s_axi_arprot   = '0;
        s_axi_arqos    = '0;
        s_axi_arregion = '0;

        repeat (3) @(negedge clk);
        check("rst_arvalid", CW'(m_axi_arvalid), CW'(0));
        check("rst_arready", CW'(s_axi_arready), CW'(1));
        check("rst_err", CW'(err_o), CW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_arready", CW'(s_axi_arready), CW'(1));
        check("post_rst_arvalid", CW'(m_axi_arvalid), CW'(0));

        // Single aligned 16-beat request fits one sub-request.
        exp_sub(64'h1000, 8'd15, 6'd5, 15'h5A3C);
        exp_burst(6'd5, 16);
        send_req(6'd5, 64'h1000, 8'd15, 15'h5A3C);
        drain();

        // 32 beats split at 512 B, issued on consecutive cycles.
        ar_cyc.delete();
        exp_sub(64'h1000, 8'd15, 6'd9, 15'h1234);
        exp_sub(64'h1200, 8'd15, 6'd9, 15'h1234);
        exp_burst(6'd9, 32);
        send_req(6'd9, 64'h1000, 8'd31, 15'h1234);
        drain();
        check("t2_ar_count", CW'(ar_cyc.size()), CW'(2));
        if (ar_cyc.size() == 2) check("t2_back_to_back", CW'(ar_cyc[1] - ar_cyc[0]), CW'(1));

        // Two beats before the 512 B boundary.
        exp_sub(64'h11C0, 8'd1, 6'd3, 15'h7FFF);
        exp_sub(64'h1200, 8'd1, 6'd3, 15'h7FFF);
        exp_burst(6'd3, 4);
        send_req(6'd3, 64'h11C0, 8'd3, 15'h7FFF);
        drain();

        // Unaligned byte offset survives only on the first sub-request.
        exp_sub(64'h11D3, 8'd1, 6'd7, 15'h0001);
        exp_sub(64'h1200, 8'd1, 6'd7, 15'h0001);
        exp_burst(6'd7, 4);
        send_req(6'd7, 64'h11D3, 8'd3, 15'h0001);
        drain();

        // Split across a 4 KB boundary.
        exp_sub(64'h3F80, 8'd3, 6'd6, 15'h2222);
        exp_sub(64'h4000, 8'd3, 6'd6, 15'h2222);
        exp_burst(6'd6, 8);
        send_req(6'd6, 64'h3F80, 8'd7, 15'h2222);
        drain();

        // AR and R backpressure patterns.
        ar_pat = 1'b1;
        rr_pat = 1'b1;
        for (int i = 0; i < 4; i++) exp_sub(64'(i * 32'h200), 8'd15, 6'd2, 15'h4C4C);
        exp_burst(6'd2, 64);
        send_req(6'd2, 64'h0, 8'd63, 15'h4C4C);
        drain();
        ar_pat = 1'b0;
        rr_pat = 1'b0;

        // Pending FIFO fills at 8 while no data returns; the 9th waits for one full sub-burst.
        @(negedge clk);
        man_rready = 1'b1;
        r_auto     = 1'b0;
        base       = ar_hs;
        seq0       = mon_seq;
        for (int i = 0; i < 16; i++) exp_sub(64'(i * 32'h200), 8'd15, 6'd1, 15'h0F0F);
        exp_burst(6'd1, 256);
        send_req(6'd1, 64'h0, 8'd255, 15'h0F0F);
        repeat (30) @(negedge clk);
        #2;
        check("t6_ar_issued_full", CW'(ar_hs - base), CW'(8));
        check("t6_arvalid_full", CW'(m_axi_arvalid), CW'(0));
        check("t6_arready_split", CW'(s_axi_arready), CW'(0));
        r_auto = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (ar_hs - base >= 9) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_ninth_issued", CW'(ok), CW'(1));
        check("t6_ninth_after_16_beats", CW'(ar_snap - seq0), CW'(16));
        drain();

        // Reset in the middle of a split: two subs accepted, third stalled, then discarded.
        @(negedge clk);
        r_auto = 1'b0;
        base   = ar_hs;
        exp_sub(64'h2000, 8'd15, 6'd4, 15'h3333);
        exp_sub(64'h2200, 8'd15, 6'd4, 15'h3333);
        send_req(6'd4, 64'h2000, 8'd63, 15'h3333);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ar_hs - base >= 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        ar_rdy_base = 1'b0;
        check("t7_two_subs", CW'(ok), CW'(1));
        repeat (2) @(negedge clk);
        check("t7_third_pending", CW'(m_axi_arvalid), CW'(1));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rsp_q.delete();
        exp_r.delete();
        beat  = 0;
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("t7_arvalid_after_rst", CW'(m_axi_arvalid), CW'(0));
        check("t7_arready_after_rst", CW'(s_axi_arready), CW'(1));
        ar_rdy_base = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        check("t7_no_more_subs", CW'(ar_hs - base), CW'(2));
        check("t7_exp_ar_consumed", CW'(exp_ar.size()), CW'(0));

        // rlast with an empty FIFO (also shows the reset emptied it).
        man_rvalid = 1'b1;
        man_rlast  = 1'b1;
        man_rready = 1'b1;
        @(negedge clk);
        #1;
        check("t9_rlast_passthru", CW'(s_axi_rlast), CW'(1));
        check("t9_err_not_yet", CW'(err_o), CW'(0));
        man_rvalid = 1'b0;
        man_rlast  = 1'b0;
        @(negedge clk);
        #1;
        check("t9_err_set", CW'(err_o), CW'(1));
        repeat (5) @(negedge clk);
        check("t9_err_sticky", CW'(err_o), CW'(1));

        r_auto = 1'b1;
        exp_sub(64'h1000, 8'd15, 6'd5, 15'h5A3C);
        exp_burst(6'd5, 16);
        send_req(6'd5, 64'h1000, 8'd15, 15'h5A3C);
        drain();
        check("t9_err_survives_traffic", CW'(err_o), CW'(1));

        rst_n = 1'b0;
        @(negedge clk);
        check("t10_err_cleared", CW'(err_o), CW'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
